rd_deserializer: RTL and testbench

Receive-side counterpart of the RD (radio detector) serial link. Samples the two source-synchronous serial lanes while ENABLE_XFR is high and deframes each lane into 12-bit words with an odd-parity check. Writes each received word pair into a dual-port trace memory through a simple write port, and reports per-transfer status (word count, parity errors, truncation, overflow) to the PS-side register block.

---
 rtl/rd_pkg.sv | 20 ++
 rtl/rd_lane_deser.sv | 31 +++
 rtl/rd_deserializer.sv | 97 +++++++++
 tb/tb_rd_deserializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rd_pkg.sv
// rd_pkg: shared constants, state encoding and WR_DATA layout for the RD serial link
package rd_pkg;
  localparam int RD_DATA_BITS = 12;
  localparam int RD_FRAME_BITS = 13;
  localparam int WD_LANE0_LSB = 0;
  localparam int WD_PERR0_BIT = 12;
  localparam int WD_LANE1_LSB = 16;
  localparam int WD_PERR1_BIT = 28;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  function automatic logic [31:0] pack_wr_data(input logic [RD_DATA_BITS-1:0] w0, input logic p0,
                                               input logic [RD_DATA_BITS-1:0] w1, input logic p1);
    logic [31:0] d;
    d = '0;
    d[WD_LANE0_LSB +: RD_DATA_BITS] = w0;
    d[WD_PERR0_BIT] = p0;
    d[WD_LANE1_LSB +: RD_DATA_BITS] = w1;
    d[WD_PERR1_BIT] = p1;
    return d;
  endfunction
endpackage

// File: rtl/rd_lane_deser.sv
// rd_lane_deser: one lane shift register with running odd-parity check
module rd_lane_deser
  import rd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic                    clr,
  input  logic                    frame_end,
  input  logic                    din,
  output logic [RD_DATA_BITS-1:0] word,
  output logic                    perr
);
  logic [RD_DATA_BITS-1:0] sr;
  logic par;
  // the parity bit is never shifted in; it only closes the running XOR
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
      par <= 1'b0;
    end else if (shift) begin
      if (frame_end) par <= 1'b0;
      else begin
        sr <= {sr[RD_DATA_BITS-2:0], din};
        par <= par ^ din;
      end
    end
  end
  assign word = sr;
  assign perr = ~(par ^ din);
endmodule

// File: rtl/rd_deserializer.sv
// rd_deserializer: two-lane RD deframer writing word pairs to trace memory with transfer status
module rd_deserializer
  import rd_pkg::*;
#(
  parameter int MEM_SIZE = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  LOCAL_CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  ENABLE_XFR,
  input  logic                  SERIAL_IN0,
  input  logic                  SERIAL_IN1,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [31:0]           WR_DATA,
  output logic                  BUSY,
  output logic                  XFR_DONE,
  output logic [ADDR_WIDTH:0]   WORD_COUNT,
  output logic [ADDR_WIDTH:0]   PERR_COUNT0,
  output logic [ADDR_WIDTH:0]   PERR_COUNT1,
  output logic                  TRUNCATED,
  output logic                  OVERFLOW
);
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(MEM_SIZE);
  state_t state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic start, shifting, frame_end, shift, room;
  logic [RD_DATA_BITS-1:0] word0, word1;
  logic perr0, perr1;
  always_comb begin
    start = state == S_IDLE && ENABLE && ENABLE_XFR;
    shifting = state == S_SHIFT && ENABLE && ENABLE_XFR;
    frame_end = shifting && bit_cnt == 4'(RD_FRAME_BITS - 1);
    shift = start || shifting;
    room = WORD_COUNT < CAP;
    state_nx = !ENABLE ? S_IDLE :
               state == S_IDLE ? (ENABLE_XFR ? S_SHIFT : S_IDLE) :
               state == S_SHIFT ? (ENABLE_XFR ? S_SHIFT : S_DONE) : S_IDLE;
    // on the SHIFT->DONE edge the count is kept so DONE can judge truncation
    bit_cnt_nx = start ? 4'd1 :
                 frame_end ? 4'd0 :
                 shifting ? bit_cnt + 4'd1 :
                 (state == S_SHIFT && ENABLE) ? bit_cnt : 4'd0;
  end
  always_ff @(posedge LOCAL_CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end
  rd_lane_deser u_lane0 (
    .clk(LOCAL_CLK), .rst(RESET), .shift(shift), .clr(!shift), .frame_end(frame_end),
    .din(SERIAL_IN0), .word(word0), .perr(perr0)
  );
  rd_lane_deser u_lane1 (
    .clk(LOCAL_CLK), .rst(RESET), .shift(shift), .clr(!shift), .frame_end(frame_end),
    .din(SERIAL_IN1), .word(word1), .perr(perr1)
  );
  always_ff @(posedge LOCAL_CLK) begin
    if (RESET) begin
      WR_EN <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      XFR_DONE <= 1'b0;
      WORD_COUNT <= '0;
      PERR_COUNT0 <= '0;
      PERR_COUNT1 <= '0;
      TRUNCATED <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      XFR_DONE <= state == S_DONE && ENABLE;
      if (start) begin
        WORD_COUNT <= '0;
        PERR_COUNT0 <= '0;
        PERR_COUNT1 <= '0;
        TRUNCATED <= 1'b0;
        OVERFLOW <= 1'b0;
      end
      if (frame_end && room) begin
        WR_EN <= 1'b1;
        WR_ADDR <= WORD_COUNT[ADDR_WIDTH-1:0];
        WR_DATA <= pack_wr_data(word0, perr0, word1, perr1);
        WORD_COUNT <= WORD_COUNT + (ADDR_WIDTH+1)'(1);
        PERR_COUNT0 <= PERR_COUNT0 + (ADDR_WIDTH+1)'(perr0);
        PERR_COUNT1 <= PERR_COUNT1 + (ADDR_WIDTH+1)'(perr1);
      end
      if (frame_end && !room) OVERFLOW <= 1'b1;
      if (state == S_DONE && ENABLE) TRUNCATED <= bit_cnt != 4'd0;
    end
  end
  assign BUSY = state == S_SHIFT;
endmodule

// File: tb/tb_rd_deserializer.sv
// tb_rd_deserializer: directed vectors against a full-size and a 4-entry deserializer
module tb_rd_deserializer;
  logic LOCAL_CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, ENABLE_XFR = 1'b0;
  logic SERIAL_IN0 = 1'b0, SERIAL_IN1 = 1'b0;
  logic WR_EN, BUSY, XFR_DONE, TRUNCATED, OVERFLOW;
  logic [10:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [11:0] WORD_COUNT, PERR_COUNT0, PERR_COUNT1;
  logic s_wr_en, s_busy, s_done, s_trunc, s_ovf;
  logic [1:0] s_addr;
  logic [31:0] s_data;
  logic [2:0] s_wc, s_pc0, s_pc1;
  int total = 0, bad = 0, cyc = 0;
  int wr_n = 0, done_n = 0, sm_n = 0;
  int wa[512], wc[512], sa[512], dcyc;
  logic [31:0] wd[512], sd[512];
  logic [11:0] l0[64], l1[64];
  logic f0[64], f1[64];
  rd_deserializer u_big (
    .LOCAL_CLK(LOCAL_CLK), .RESET(RESET), .ENABLE(ENABLE), .ENABLE_XFR(ENABLE_XFR),
    .SERIAL_IN0(SERIAL_IN0), .SERIAL_IN1(SERIAL_IN1), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .BUSY(BUSY), .XFR_DONE(XFR_DONE), .WORD_COUNT(WORD_COUNT),
    .PERR_COUNT0(PERR_COUNT0), .PERR_COUNT1(PERR_COUNT1), .TRUNCATED(TRUNCATED), .OVERFLOW(OVERFLOW)
  );
  rd_deserializer #(.MEM_SIZE(4), .ADDR_WIDTH(2)) u_small (
    .LOCAL_CLK(LOCAL_CLK), .RESET(RESET), .ENABLE(ENABLE), .ENABLE_XFR(ENABLE_XFR),
    .SERIAL_IN0(SERIAL_IN0), .SERIAL_IN1(SERIAL_IN1), .WR_EN(s_wr_en), .WR_ADDR(s_addr),
    .WR_DATA(s_data), .BUSY(s_busy), .XFR_DONE(s_done), .WORD_COUNT(s_wc),
    .PERR_COUNT0(s_pc0), .PERR_COUNT1(s_pc1), .TRUNCATED(s_trunc), .OVERFLOW(s_ovf)
  );
  always #5 LOCAL_CLK = ~LOCAL_CLK;
  always @(posedge LOCAL_CLK) cyc <= cyc + 1;
  always @(negedge LOCAL_CLK) begin
    if (WR_EN) begin
      wa[wr_n] = int'(WR_ADDR);
      wd[wr_n] = WR_DATA;
      wc[wr_n] = cyc;
      wr_n = wr_n + 1;
    end
    if (XFR_DONE) begin
      dcyc = cyc;
      done_n = done_n + 1;
    end
    if (s_wr_en) begin
      sa[sm_n] = int'(s_addr);
      sd[sm_n] = s_data;
      sm_n = sm_n + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_data(input int w);
    return {3'b0, f1[w], l1[w], 3'b0, f0[w], l0[w]};
  endfunction
  task automatic load_stream(input int n);
    for (int k = 0; k < 64; k++) begin
      l0[k] = 12'(k);
      l1[k] = 12'(4096 - k);
      f0[k] = 1'b0;
      f1[k] = 1'b0;
    end
  endtask
  task automatic send(input int nbits, input int abort_at, input int kind);
    int w, b;
    for (int i = 0; i < nbits; i++) begin
      @(negedge LOCAL_CLK);
      if (i == 3) chk("busy_mid", 32'(BUSY), 32'd1);
      if (i == abort_at) begin
        if (kind == 1) RESET = 1'b1;
        else ENABLE = 1'b0;
        ENABLE_XFR = 1'b0;
        repeat (2) @(negedge LOCAL_CLK);
        RESET = 1'b0;
        ENABLE = 1'b1;
        break;
      end
      w = i / 13;
      b = i % 13;
      ENABLE_XFR = 1'b1;
      SERIAL_IN0 = b < 12 ? l0[w][11-b] : (~^l0[w]) ^ f0[w];
      SERIAL_IN1 = b < 12 ? l1[w][11-b] : (~^l1[w]) ^ f1[w];
    end
    @(negedge LOCAL_CLK);
    ENABLE_XFR = 1'b0;
    SERIAL_IN0 = 1'b0;
    SERIAL_IN1 = 1'b0;
    repeat (6) @(negedge LOCAL_CLK);
  endtask
  initial begin
    int wb, db, sb;
    repeat (3) @(negedge LOCAL_CLK);
    RESET = 1'b0;
    @(negedge LOCAL_CLK);
    chk("rst_wr_en", 32'(WR_EN), 0);
    chk("rst_addr", 32'(WR_ADDR), 0);
    chk("rst_data", WR_DATA, 0);
    chk("rst_flags", {BUSY, XFR_DONE, TRUNCATED, OVERFLOW}, 0);
    chk("rst_counts", {PERR_COUNT1, PERR_COUNT0, WORD_COUNT[7:0]}, 0);
    ENABLE = 1'b1;
    @(negedge LOCAL_CLK);
    // single word
    load_stream(1);
    l0[0] = 12'h000;
    l1[0] = 12'hFFF;
    wb = wr_n; db = done_n;
    send(13, -1, 0);
    chk("w1_writes", wr_n - wb, 1);
    chk("w1_addr", wa[wb], 0);
    chk("w1_data", wd[wb], 32'h0FFF0000);
    chk("w1_done", done_n - db, 1);
    chk("w1_done_lat", dcyc - wc[wb], 2);
    chk("w1_wc", 32'(WORD_COUNT), 1);
    chk("w1_perr", {PERR_COUNT1, PERR_COUNT0}, 0);
    chk("w1_flags", {TRUNCATED, OVERFLOW}, 0);
    // 32-word stream
    load_stream(32);
    wb = wr_n;
    send(32 * 13, -1, 0);
    chk("st_writes", wr_n - wb, 32);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("st_addr%0d", k), wa[wb+k], k);
      chk($sformatf("st_data%0d", k), wd[wb+k], exp_data(k));
      if (k > 0) chk($sformatf("st_gap%0d", k), wc[wb+k] - wc[wb+k-1], 13);
    end
    chk("st_wc", 32'(WORD_COUNT), 32);
    chk("st_flags", {TRUNCATED, OVERFLOW}, 0);
    chk("st_perr", {PERR_COUNT1, PERR_COUNT0}, 0);
    // lane1 parity error on word 5
    load_stream(8);
    f1[5] = 1'b1;
    wb = wr_n;
    send(8 * 13, -1, 0);
    chk("pe_writes", wr_n - wb, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("pe_bit28_%0d", k), 32'(wd[wb+k][28]), 32'(k == 5));
    chk("pe_data5", wd[wb+5], 32'h1FFB0005);
    chk("pe_cnt1", 32'(PERR_COUNT1), 1);
    chk("pe_cnt0", 32'(PERR_COUNT0), 0);
    // truncated after 13+7 bits
    load_stream(2);
    wb = wr_n; db = done_n;
    send(20, -1, 0);
    chk("tr_writes", wr_n - wb, 1);
    chk("tr_trunc", 32'(TRUNCATED), 1);
    chk("tr_wc", 32'(WORD_COUNT), 1);
    chk("tr_done", done_n - db, 1);
    // overflow on the 4-entry instance
    load_stream(6);
    wb = wr_n; sb = sm_n;
    send(6 * 13, -1, 0);
    chk("ov_writes", sm_n - sb, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ov_addr%0d", k), sa[sb+k], k);
      chk($sformatf("ov_data%0d", k), sd[sb+k], exp_data(k));
    end
    chk("ov_flag", 32'(s_ovf), 1);
    chk("ov_wc", 32'(s_wc), 4);
    chk("ov_big_wc", 32'(WORD_COUNT), 6);
    chk("ov_big_flag", 32'(OVERFLOW), 0);
    // reset at bit 6 of word 2
    load_stream(4);
    db = done_n;
    send(4 * 13, 32, 1);
    chk("rs_done", done_n - db, 0);
    chk("rs_wc", 32'(WORD_COUNT), 0);
    chk("rs_data", WR_DATA, 0);
    chk("rs_addr", 32'(WR_ADDR), 0);
    chk("rs_flags", {WR_EN, BUSY, XFR_DONE, TRUNCATED, OVERFLOW}, 0);
    chk("rs_perr", {PERR_COUNT1, PERR_COUNT0}, 0);
    // enable dropped at bit 6 of word 2
    db = done_n;
    send(4 * 13, 32, 2);
    chk("en_done", done_n - db, 0);
    chk("en_wc", 32'(WORD_COUNT), 2);
    chk("en_busy", 32'(BUSY), 0);
    chk("en_flags", {TRUNCATED, OVERFLOW}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
